enc164_capture: RTL and testbench
=================================

# enc164_capture

Registered 16-to-4 priority encoder with input synchronisation, debounce and a valid/ready output handshake. It is the return path of the 7-segment datapath's 4-to-16 decoder: it turns a 16-line one-hot (or multi-hot) switch/key vector back into the 4-bit code the decoder consumes. It sits between the board's raw input lines and the display/control logic.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised vector must stay unchanged before capture; legal range 1..255
- clk  input  1  single rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  block enable; low forces IDLE
- req  input  16  raw request lines, asynchronous to clk
- ready  input  1  consumer accepts code when high with valid
- code  output  4  encoded value of the winning line
- multi  output  1  more than one line was set in the captured vector
- valid  output  1  code/multi hold a captured value
- busy  output  1  state is not IDLE

## Operation
- Bit-to-code map, exact inverse of the decoder: req[k] → code k+1 for k = 0..14; req[15] → code 0.
- Priority: highest set bit index wins (req[15] beats everything, then req[14] → code 15, down to req[0] → code 1).
- req passes through a 2-flop synchroniser (sync1, sync2); all logic uses sync2.
- States: IDLE, STABLE, VALID, RELEASE.
- IDLE: if sync2 ≠ 0 → STABLE, snapshot ← sync2, cnt ← 0.
- STABLE: if sync2 = snapshot: cnt increments; when cnt = DEBOUNCE_CYCLES−1 → VALID, code/multi loaded from snapshot. If sync2 ≠ snapshot and sync2 ≠ 0: stay STABLE, snapshot ← sync2, cnt ← 0. If sync2 = 0 → IDLE.
- VALID: valid = 1; code and multi held constant. On valid & ready → RELEASE. Changes on req are ignored in this state.
- RELEASE: valid = 0; waits for sync2 = 0, then → IDLE. Holding a key produces exactly one capture.
- enable low in any state: next edge → IDLE, valid 0, cnt 0; code/multi keep their last value. No capture while enable low.
- multi = 1 iff the snapshot had two or more bits set.
- cnt width is $clog2(DEBOUNCE_CYCLES+1); no wrap is possible because STABLE exits at DEBOUNCE_CYCLES−1.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, sync1/sync2/snapshot 0, cnt 0, code 4'h0, multi 0, valid 0, busy 0. Outputs take their reset values immediately, not at the next edge.
- Latency: req stable before edge 1 → sync2 valid after edge 2 → STABLE after edge 3 → valid high after edge 3+DEBOUNCE_CYCLES (edge 7 at default).
- Handshake: transfer on the edge where valid & ready = 1; valid is low after that edge. ready high before valid is legal, and the transfer occurs on the first edge valid is high. ready has no effect outside VALID.
- valid never deasserts without a transfer, except on enable low or reset.
- busy is registered and equals (state ≠ IDLE).
- Reset mid-debounce or mid-VALID discards the pending capture; no stale valid after reset release.
- A glitch of any width < DEBOUNCE_CYCLES cycles, measured at sync2, never produces valid.

## Test plan
- Reset: assert rst_n low mid-VALID with code = 4'h5 → code 0, valid 0, busy 0 immediately; release with req = 0 → IDLE, valid stays 0.
- Single line: req = 16'h0004, ready = 1, DEBOUNCE_CYCLES = 4 → valid high after edge 7 with code 4'h3, multi 0; one-cycle valid pulse; no second capture until req returns to 0 and is set again.
- Priority/map: req = 16'h8001 → code 0, multi 1; req = 16'h4002 → code 4'hF, multi 1; sweep each single bit k → code (k+1) mod 16.
- Debounce: req = 16'h0010 for 3 cycles, then 0 → valid never asserts; req 16'h0010 → 16'h0020 mid-count → capture code 4'h6 only, after a full count from the change.
- Backpressure: ready = 0 while valid; change req to 16'h0100 → code stays at the first value, valid held; ready = 1 → one transfer, then RELEASE until req = 0.
- Enable: drop enable in STABLE and in VALID → IDLE next edge, valid 0; raise enable with req held at 16'h0002 → new capture code 4'h2 after full sync + debounce latency.

Source files
------------

// File: rtl/enc164_capture.sv
// Registered 16-to-4 priority encoder with input synchroniser, debounce and
// a valid/ready handshake; inverse of the 4-to-16 segment decoder.
module enc164_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        multi,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned REQ_W = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STABLE, VALID, RELEASE} state_t;

  state_t             state, state_d;
  logic [REQ_W-1:0]   sync1, sync2;
  logic [REQ_W-1:0]   snapshot, snapshot_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CODE_W-1:0]  code_d, enc_code;
  logic               multi_d, valid_d, busy_d, enc_multi;

  // Highest set bit wins; bit 15 wraps to code 0 through the 4-bit cast.
  always_comb begin
    enc_code = '0;
    for (int k = 0; k < int'(REQ_W); k++) begin
      if (snapshot[k]) enc_code = CODE_W'(k + 1);
    end
    enc_multi = |(snapshot & (snapshot - REQ_W'(1)));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    snapshot_d = snapshot;
    cnt_d      = cnt;
    code_d     = code;
    multi_d    = multi;
    valid_d    = valid;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sync2 != '0) begin
            state_d    = STABLE;
            snapshot_d = sync2;
            cnt_d      = '0;
          end
        end
        STABLE: begin
          if (sync2 == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (sync2 != snapshot) begin
            snapshot_d = sync2;
            cnt_d      = '0;
          end else if (cnt == CNT_LAST) begin
            state_d = VALID;
            cnt_d   = '0;
            code_d  = enc_code;
            multi_d = enc_multi;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        VALID: begin
          if (ready) begin
            state_d = RELEASE;
            valid_d = 1'b0;
          end
        end
        RELEASE: begin
          if (sync2 == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync1    <= '0;
      sync2    <= '0;
      snapshot <= '0;
      cnt      <= '0;
      code     <= '0;
      multi    <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      sync1    <= req;
      sync2    <= sync1;
      snapshot <= snapshot_d;
      cnt      <= cnt_d;
      code     <= code_d;
      multi    <= multi_d;
      valid    <= valid_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_enc164_capture.sv
// Directed bench for enc164_capture at the default debounce depth of 4.
module tb_enc164_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        ready;
  logic [3:0]  code;
  logic        multi;
  logic        valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  enc164_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ready(ready),
    .code(code), .multi(multi), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!valid && n < maxc) begin
      tick(1);
      n++;
    end
  endtask

  // Full capture with ready high, then release and return to IDLE.
  task automatic capture(input string tag, input logic [15:0] r,
                         input logic [3:0] exp_code, input logic exp_multi);
    req = r;
    ready = 1'b1;
    tick(6);
    chk({tag, "_early"}, 16'(valid), 16'd0);
    tick(1);
    chk({tag, "_valid"}, 16'(valid), 16'd1);
    chk({tag, "_code"}, 16'(code), 16'(exp_code));
    chk({tag, "_multi"}, 16'(multi), 16'(exp_multi));
    tick(1);
    chk({tag, "_xfer"}, 16'(valid), 16'd0);
    req = '0;
    tick(3);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int hits;
    int n;
    rst_n = 1'b0;
    enable = 1'b0;
    req = '0;
    ready = 1'b0;
    #3;
    chk("rst_code", 16'(code), 16'd0);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_multi", 16'(multi), 16'd0);
    #20;
    rst_n = 1'b1;
    tick(1);
    enable = 1'b1;

    // Single line, one-cycle pulse, no repeat while held.
    req = 16'h0004;
    ready = 1'b1;
    tick(6);
    chk("single_early", 16'(valid), 16'd0);
    chk("single_busy", 16'(busy), 16'd1);
    tick(1);
    chk("single_valid", 16'(valid), 16'd1);
    chk("single_code", 16'(code), 16'h3);
    chk("single_multi", 16'(multi), 16'd0);
    tick(1);
    chk("single_pulse", 16'(valid), 16'd0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (valid) hits++;
    end
    chk("single_held_once", 16'(hits), 16'd0);
    chk("single_release", 16'(busy), 16'd1);
    req = '0;
    tick(2);
    chk("single_release2", 16'(busy), 16'd1);
    tick(1);
    chk("single_idle", 16'(busy), 16'd0);

    // Priority and map.
    capture("pri_8001", 16'h8001, 4'h0, 1'b1);
    capture("pri_4002", 16'h4002, 4'hF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      capture($sformatf("bit%0d", k), 16'(1) << k, 4'(k + 1), 1'b0);
    end

    // Glitch shorter than the debounce window.
    req = 16'h0010;
    tick(3);
    req = '0;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (valid) hits++;
    end
    chk("glitch_no_valid", 16'(hits), 16'd0);
    chk("glitch_idle", 16'(busy), 16'd0);

    // Change mid-count restarts the window on the new vector.
    req = 16'h0010;
    tick(3);
    req = 16'h0020;
    tick(6);
    chk("change_early", 16'(valid), 16'd0);
    tick(1);
    chk("change_valid", 16'(valid), 16'd1);
    chk("change_code", 16'(code), 16'h6);
    req = '0;
    tick(4);
    chk("change_idle", 16'(busy), 16'd0);

    // Backpressure holds code while req changes.
    ready = 1'b0;
    req = 16'h0008;
    tick(7);
    chk("bp_valid", 16'(valid), 16'd1);
    chk("bp_code", 16'(code), 16'h4);
    req = 16'h0100;
    tick(5);
    chk("bp_hold_valid", 16'(valid), 16'd1);
    chk("bp_hold_code", 16'(code), 16'h4);
    ready = 1'b1;
    tick(1);
    chk("bp_xfer", 16'(valid), 16'd0);
    tick(5);
    chk("bp_release_busy", 16'(busy), 16'd1);
    chk("bp_release_valid", 16'(valid), 16'd0);
    req = '0;
    tick(3);
    chk("bp_idle", 16'(busy), 16'd0);

    // Enable drop in STABLE.
    req = 16'h0002;
    tick(4);
    chk("en_stable_busy", 16'(busy), 16'd1);
    enable = 1'b0;
    tick(1);
    chk("en_stable_drop", 16'(busy), 16'd0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (valid || busy) hits++;
    end
    chk("en_low_quiet", 16'(hits), 16'd0);
    req = '0;
    enable = 1'b1;
    tick(3);

    // Enable drop in VALID, then recapture with req held.
    ready = 1'b0;
    req = 16'h0040;
    tick(7);
    chk("en_valid_code", 16'(code), 16'h7);
    chk("en_valid_valid", 16'(valid), 16'd1);
    enable = 1'b0;
    tick(1);
    chk("en_drop_valid", 16'(valid), 16'd0);
    chk("en_drop_busy", 16'(busy), 16'd0);
    chk("en_drop_code", 16'(code), 16'h7);
    req = 16'h0002;
    tick(4);
    enable = 1'b1;
    wait_valid(10, n);
    chk("en_recap_latency", 16'(n >= 5 && n <= 7), 16'd1);
    chk("en_recap_code", 16'(code), 16'h2);
    chk("en_recap_multi", 16'(multi), 16'd0);
    ready = 1'b1;
    tick(1);
    req = '0;
    tick(4);
    chk("en_recap_idle", 16'(busy), 16'd0);

    // Asynchronous reset mid-VALID.
    ready = 1'b0;
    req = 16'h0010;
    tick(7);
    chk("rst2_pre_valid", 16'(valid), 16'd1);
    chk("rst2_pre_code", 16'(code), 16'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_code", 16'(code), 16'd0);
    chk("rst2_valid", 16'(valid), 16'd0);
    chk("rst2_busy", 16'(busy), 16'd0);
    req = '0;
    #20;
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (valid || busy) hits++;
    end
    chk("rst2_no_stale", 16'(hits), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
